// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds two WIDTH-bit operands by reusing one CHUNK-bit ripple slice over N = WIDTH/CHUNK
//   cycles. The carry is registered between chunks. The input side uses valid/ready and so
//   does the output side. Only one operation is in flight at a time.
//   WIDTH must be a multiple of CHUNK and at least CHUNK.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : requester presents a, b, cin (sampled only on the acceptance edge)
//   in_ready   : block is idle and will accept an operation
//   a, b       : operands
//   cin        : carry into chunk 0
//   out_valid  : sum/cout/ovf are valid and held until out_ready
//   out_ready  : consumer accepts the result
//   sum        : a + b + cin modulo 2^WIDTH
//   cout       : unsigned carry out of the MSB
//   ovf        : signed overflow (carry into MSB xor carry out of MSB)
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    // Shared adder slice
    logic [CHUNK-1:0] op_a, op_b, slice_sum;
    logic             slice_cout, slice_cmsb;
    logic             c;

    // Operand chunk select, decoded with constant part-selects
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx_q == IdxW'(k)) begin
                op_a = a_q[k*CHUNK +: CHUNK];
                op_b = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Ripple chain; slice_cmsb is the carry into the slice's top bit, which on the last chunk
    // is the carry into bit WIDTH-1.
    always_comb begin
        slice_sum  = '0;
        c          = carry_q;
        slice_cmsb = carry_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            slice_cmsb   = c;
            slice_sum[i] = op_a[i] ^ op_b[i] ^ c;
            c            = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
        end
        slice_cout = c;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (idx_q == IdxW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH=16, 4 and 32 (CHUNK=4).
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t q16[$];
    res_t q4[$];
    res_t q32[$];

    // ---------------- WIDTH=16 ----------------
    logic        v16, r16, ov16, or16, cin16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    res_t        last16;

    nibble_serial_adder_ctrl #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16)
    );

    task automatic push16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] full;
        res_t r;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r.sum  = {16'd0, full[15:0]};
        r.cout = full[16];
        r.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        q16.push_back(r);
    endtask

    // Drives one request; returns #1 after the acceptance edge.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        check("w16 in_ready before accept", 64'(r16), 64'd1);
        a16 = a; b16 = b; cin16 = c; v16 = 1'b1;
        push16(a, b, c);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        cin16 = 1'($urandom);
    endtask

    task automatic wait16(input int exp_lat, input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov16 && lat < 40);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        last16 = q16.pop_front();
        check({tag, " sum"}, 64'(s16), 64'(last16.sum));
        check({tag, " cout"}, 64'(co16), 64'(last16.cout));
        check({tag, " ovf"}, 64'(ovf16), 64'(last16.ovf));
    endtask

    task automatic finish16(input string tag);
        @(posedge clk);
        #1;
        check({tag, " out_valid after transfer"}, 64'(ov16), 64'd0);
        check({tag, " in_ready after transfer"}, 64'(r16), 64'd1);
    endtask

    // ---------------- WIDTH=4 ----------------
    logic       v4, r4, ov4, or4, cin4, co4, ovf4;
    logic [3:0] a4, b4, s4;

    nibble_serial_adder_ctrl #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
        .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ovf4)
    );

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] full;
        res_t r;
        int lat;
        full   = {1'b0, a} + {1'b0, b} + {4'd0, c};
        r.sum  = {28'd0, full[3:0]};
        r.cout = full[4];
        r.ovf  = (a[3] == b[3]) && (full[3] != a[3]);
        @(negedge clk);
        check("w4 in_ready", 64'(r4), 64'd1);
        a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
        q4.push_back(r);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov4 && lat < 40);
        check("w4 latency", 64'(lat), 64'd1);
        r = q4.pop_front();
        check("w4 sum", 64'(s4), 64'(r.sum));
        check("w4 cout", 64'(co4), 64'(r.cout));
        check("w4 ovf", 64'(ovf4), 64'(r.ovf));
        @(posedge clk);
        #1;
    endtask

    // ---------------- WIDTH=32 ----------------
    logic        v32, r32, ov32, or32, cin32, co32, ovf32;
    logic [31:0] a32, b32, s32;

    nibble_serial_adder_ctrl #(.WIDTH(32), .CHUNK(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
        .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(ovf32)
    );

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        res_t r;
        int lat;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        @(negedge clk);
        check("w32 in_ready", 64'(r32), 64'd1);
        a32 = a; b32 = b; cin32 = c; v32 = 1'b1;
        q32.push_back(r);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov32 && lat < 40);
        check("w32 latency", 64'(lat), 64'd8);
        r = q32.pop_front();
        check("w32 sum", 64'(s32), 64'(r.sum));
        check("w32 cout", 64'(co32), 64'(r.cout));
        check("w32 ovf", 64'(ovf32), 64'(r.ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
        v4  = 1'b0; or4  = 1'b1; a4  = '0; b4  = '0; cin4  = 1'b0;
        v32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0;
        #12;
        check("reset in_ready", 64'(r16), 64'd1);
        check("reset out_valid", 64'(ov16), 64'd0);
        check("reset sum", 64'(s16), 64'd0);
        check("reset cout", 64'(co16), 64'd0);
        check("reset ovf", 64'(ovf16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic carries and overflow cases
        start16(16'h00FF, 16'h0001, 1'b0); wait16(4, "t1"); finish16("t1");
        start16(16'hFFFF, 16'h0001, 1'b0); wait16(4, "t2a"); finish16("t2a");
        start16(16'h7FFF, 16'h0001, 1'b0); wait16(4, "t2b"); finish16("t2b");
        start16(16'h1234, 16'h4321, 1'b1); wait16(4, "t3a"); finish16("t3a");
        start16(16'h8000, 16'h8000, 1'b0); wait16(4, "t3b"); finish16("t3b");

        // Backpressure with a pending request held on the input
        or16 = 1'b0;
        start16(16'h0F0F, 16'h0101, 1'b0);
        wait16(4, "t4a");
        a16 = 16'h1111; b16 = 16'h1111; cin16 = 1'b0; v16 = 1'b1;
        push16(16'h1111, 16'h1111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("t4 hold out_valid", 64'(ov16), 64'd1);
            check("t4 hold in_ready", 64'(r16), 64'd0);
            check("t4 hold sum", 64'(s16), 64'(last16.sum));
            check("t4 hold cout", 64'(co16), 64'(last16.cout));
            check("t4 hold ovf", 64'(ovf16), 64'(last16.ovf));
        end
        or16 = 1'b1;
        @(posedge clk);
        #1;
        check("t4 idle after transfer", 64'(r16), 64'd1);
        check("t4 out_valid after transfer", 64'(ov16), 64'd0);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        check("t4 second accepted", 64'(r16), 64'd0);
        wait16(4, "t4b");
        finish16("t4b");

        // Asynchronous reset mid-RUN
        start16(16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 out_valid in reset", 64'(ov16), 64'd0);
        check("t5 sum in reset", 64'(s16), 64'd0);
        check("t5 in_ready in reset", 64'(r16), 64'd1);
        void'(q16.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        start16(16'h0003, 16'h0004, 1'b0); wait16(4, "t5"); finish16("t5");

        // Parameter sweep with random operands
        for (int i = 0; i < 8; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        end
        op4(4'hF, 4'h0, 1'b1);
        op4(4'h7, 4'h1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            op32($urandom, $urandom, 1'($urandom));
        end
        op32(32'hFFFF_FFFF, 32'h0, 1'b1);
        op32(32'h7FFF_FFFF, 32'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
